regfile_mp: RTL and testbench

//  Parametrised integer register file for the core: NREAD asynchronous read ports, one synchronous write port.

---
 rtl/regfile_pkg.sv | 6 +
 rtl/regfile_init_seq.sv | 28 ++
 rtl/regfile_mp.sv | 40 ++++
 tb/tb_regfile_mp.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the multi-port register file
package regfile_pkg;
  typedef enum logic {RF_INIT, RF_READY} rf_state_t;
  localparam int RF_XLEN_DEF = 32;
  localparam int RF_NREGS_DEF = 32;
endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: post-reset sweep that clears storage entries 1..NREGS-1, then raises ready
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DEF,
  parameter int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic          ready
);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  rf_state_t state;
  logic [AW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RF_INIT;
      cnt <= AW'(1);
    end else if (state == RF_INIT) begin
      if (cnt == LAST) state <= RF_READY;
      else cnt <= cnt + 1'b1;
    end
  assign init_we = state == RF_INIT;
  assign init_addr = cnt;
  assign ready = state == RF_READY;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NREAD async read ports, one sync write port, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN for write-first forwarding; otherwise reads are read-first.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = RF_XLEN_DEF,
  parameter int NREGS = RF_NREGS_DEF,
  parameter int NREAD = 2,
  parameter int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  we,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic                  ready
);
  logic [XLEN-1:0] mem [NREGS];
  logic init_we, user_we;
  logic [AW-1:0] init_addr;
  regfile_init_seq #(.NREGS(NREGS), .AW(AW)) u_seq (
    .clk(clk), .rst_n(rst_n), .init_we(init_we), .init_addr(init_addr), .ready(ready)
  );
  assign user_we = we && ready && wr_addr != '0;
  // single storage write port shared by the clearing sweep and writeback
  always_ff @(posedge clk)
    if (init_we || user_we) mem[init_we ? init_addr : wr_addr] <= init_we ? '0 : wr_data;
  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    assign rd_data[i*XLEN +: XLEN] = (!ready || a == '0) ? '0 :
                                     (user_we && a == wr_addr) ? wr_data : mem[a];
`else
    assign rd_data[i*XLEN +: XLEN] = (!ready || a == '0) ? '0 : mem[a];
`endif
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp (32x32x2 and 16x32x3 instances)
module tb_regfile_mp;
  logic clk = 0;
  logic rst_n = 0;
  logic [9:0] a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic a_we = 0;
  logic [4:0] a_wr_addr = '0;
  logic [31:0] a_wr_data = '0;
  logic a_ready;
  logic [11:0] b_rd_addr = '0;
  logic [95:0] b_rd_data;
  logic b_we = 0;
  logic [3:0] b_wr_addr = '0;
  logic [31:0] b_wr_data = '0;
  logic b_ready;
  int total = 0, passed = 0;
  typedef struct {string name; int sel; logic [31:0] exp;} chk_t;
  chk_t q[$];
  regfile_mp dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .we(a_we), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .ready(a_ready)
  );
  regfile_mp #(.NREGS(16), .NREAD(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .we(b_we), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .ready(b_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] pick(int sel);
    case (sel)
      0: return a_rd_data[31:0];
      1: return a_rd_data[63:32];
      2: return {31'b0, a_ready};
      10: return b_rd_data[31:0];
      11: return b_rd_data[63:32];
      12: return b_rd_data[95:64];
      default: return {31'b0, b_ready};
    endcase
  endfunction
  always @(negedge clk)
    while (q.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      act = pick(c.sel);
      total++;
      if (act === c.exp) passed++;
      else $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
    end
  task automatic expect_v(string name, int sel, logic [31:0] exp);
    q.push_back('{name, sel, exp});
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(string tag);
    for (int k = 1; k <= 31; k++) begin
      step();
      expect_v($sformatf("%s_ready_a_e%0d", tag, k), 2, {31'b0, k >= 31});
      expect_v($sformatf("%s_ready_b_e%0d", tag, k), 13, {31'b0, k >= 15});
      if (k == 1) expect_v({tag, "_init_rd"}, 0, 32'h0);
      if (k == 31) a_we = 0;
    end
  endtask
  initial begin
    int n;
    wait (rst_n === 1'b1);
    n = 0;
    while (a_ready !== 1'b1 && n < 40) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (a_ready === 1'b1) passed++;
    else $display("FAIL wait_ready_timeout: ready not high after %0d edges", n);
  end
  initial begin
    a_we = 1; a_wr_addr = 5; a_wr_data = 32'hDEAD; a_rd_addr = {5'd0, 5'd5};
    expect_v("rst_ready_a", 2, 0);
    expect_v("rst_ready_b", 13, 0);
    expect_v("rst_rd", 0, 0);
    step();
    total++;
    if (a_ready === 1'b0 && b_ready === 1'b0) passed++;
    else $display("FAIL rst_state_direct: ready_a %b ready_b %b", a_ready, b_ready);
    rst_n = 1;
    sweep("t1");
    expect_v("t1_x5_ignored", 0, 0);
    step();
    a_we = 1; a_wr_addr = 1; a_wr_data = 7;
    step();
    a_we = 0; a_rd_addr = {5'd1, 5'd0};
    expect_v("t2_x1_p1", 1, 32'h7);
    expect_v("t2_x0_p0", 0, 0);
    step();
    a_we = 1; a_wr_addr = 0; a_wr_data = 32'hFFFF_FFFF; a_rd_addr = '0;
    expect_v("t3_x0_during", 0, 0);
    step();
    a_we = 0;
    expect_v("t3_x0_p0", 0, 0);
    expect_v("t3_x0_p1", 1, 0);
    a_we = 1; a_wr_addr = 3; a_wr_data = 1;
    step();
    a_wr_data = 9; a_rd_addr = {5'd3, 5'd3};
`ifdef REGFILE_BYPASS_EN
    expect_v("t4_same_cycle_p0", 0, 9);
    expect_v("t4_same_cycle_p1", 1, 9);
`else
    expect_v("t4_same_cycle_p0", 0, 1);
    expect_v("t4_same_cycle_p1", 1, 1);
`endif
    step();
    a_we = 0;
    expect_v("t4_after_p0", 0, 9);
    expect_v("t4_after_p1", 1, 9);
    step();
    rst_n = 0;
    expect_v("t5_rst_ready", 2, 0);
    step();
    rst_n = 1;
    for (int k = 1; k <= 10; k++) step();
    rst_n = 0;
    expect_v("t5_pulse_ready_a", 2, 0);
    expect_v("t5_pulse_ready_b", 13, 0);
    step();
    rst_n = 1;
    sweep("t5");
    for (int r = 0; r < 32; r++) begin
      a_rd_addr = {5'(31 - r), 5'(r)};
      expect_v($sformatf("t5_clr_p0_x%0d", r), 0, 0);
      expect_v($sformatf("t5_clr_p1_x%0d", 31 - r), 1, 0);
      step();
    end
    b_we = 1; b_wr_addr = 15; b_wr_data = 32'hA5A5_A5A5;
    step();
    b_we = 0; b_rd_addr = {4'd15, 4'd15, 4'd15};
    expect_v("t6_p0", 10, 32'hA5A5_A5A5);
    expect_v("t6_p1", 11, 32'hA5A5_A5A5);
    expect_v("t6_p2", 12, 32'hA5A5_A5A5);
    step();
    b_rd_addr = {4'd0, 4'd14, 4'd15};
    expect_v("t6_x15_again", 10, 32'hA5A5_A5A5);
    expect_v("t6_x14_zero", 11, 0);
    expect_v("t6_x0_zero", 12, 0);
    step();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
